operand_skewer: RTL and testbench
=================================

OPERAND_SKEWER -- requirements
Module: operand_skewer

Interface
REQ-001 SHALL have parameter N1, default 4, systolic array rows (A lanes per beat).
REQ-002 SHALL have parameter N2, default 4, systolic array columns (B lanes per beat).
REQ-003 SHALL have parameter M, default 8, shared inner dimension (beats per tile).
REQ-004 SHALL have parameter DW, default 8, operand element width in bits.
REQ-005 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, begin one tile (pulse).
REQ-008 SHALL have port in_valid, input, 1, a_data/b_data carry one beat.
REQ-009 SHALL have port a_data, input, N1*DW, one A slice from buffer A; lane i = bits [i*DW +: DW].
REQ-010 SHALL have port b_data, input, N2*DW, one B slice from buffer B; lane j = bits [j*DW +: DW].
REQ-011 SHALL have port a_skew, output, N1*DW, skewed A operands to array row inputs.
REQ-012 SHALL have port a_vld, output, N1, per-row operand valid.
REQ-013 SHALL have port b_skew, output, N2*DW, skewed B operands to array column inputs.
REQ-014 SHALL have port b_vld, output, N2, per-column operand valid.
REQ-015 SHALL have port clear, output, 1, one-cycle accumulator clear to array PEs.
REQ-016 SHALL have port busy, output, 1, high in FEED or FLUSH.
REQ-017 SHALL have port done, output, 1, one-cycle pulse when tile fully drained.

Function
REQ-018 SHALL implement FSM states IDLE, FEED, FLUSH, DONE.
REQ-019 IDLE: start=1 -> FEED next cycle; clear=1 for exactly that cycle (registered off the accepting edge).
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 FEED: beat accepted when in_valid=1; beat counter (width $clog2(M+1)) increments per accepted beat.
REQ-022 in_valid SHALL be ignored in IDLE, FLUSH, DONE; no beat counted, zeros injected.
REQ-023 FEED -> FLUSH on the cycle the M-th beat is accepted; beat counter returns to 0.
REQ-024 FLUSH SHALL last exactly N1+N2-1 cycles (flush counter), then -> DONE.
REQ-025 DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-026 A lane i output SHALL equal a_data lane i from exactly i+1 cycles earlier; a_vld[i] = accepted-beat flag from i+1 cycles earlier.
REQ-027 B lane j output SHALL equal b_data lane j from exactly j+1 cycles earlier; b_vld[j] likewise.
REQ-028 Non-accepted cycles (gaps, other states) SHALL enter delay lines as data 0, vld 0; bubbles propagate unchanged in position.
REQ-029 Data SHALL pass bit-exact; no arithmetic, no width change.
REQ-030 busy SHALL be combinational decode of FEED|FLUSH.
REQ-031 Lanes SHALL keep shifting in every state, so FLUSH drains the last beat to lane N1-1/N2-1.

Reset
REQ-032 rst=0 SHALL asynchronously force state IDLE, all counters 0, all delay-line data and vld 0.
REQ-033 All outputs SHALL be 0 during and immediately after reset.
REQ-034 Reset mid-FEED/FLUSH SHALL abort the tile; no done pulse issued.

Structure
REQ-035 Shared package SHALL hold FSM state enum and a max/clog2-safe helper function.
REQ-036 Sub-module skew_delay_line (params DEPTH, DW; data+vld shift register, async active-low reset) SHALL be instantiated once per lane, DEPTH = lane index + 1.

Verification (N1=N2=4, M=8, DW=8)
REQ-037 start at cycle 0, in_valid=1 cycles 1..8, a lane k = 8'h10*beat+k -> clear at cycle 1; a_skew lane 3 shows beat 1 value 8'h13 at cycle 5; done at cycle 16.
REQ-038 in_valid low on cycles 3 and 4 of FEED -> 10 FEED cycles, a_vld/b_vld show 2-cycle holes on every lane at lane-delayed offsets; done 2 cycles later than REQ-037.
REQ-039 start pulsed again during FEED and FLUSH -> ignored; exactly one clear, one done.
REQ-040 rst asserted during FLUSH -> all outputs 0 same cycle, no done; new start then completes normally.
REQ-041 in_valid=1 with nonzero data while IDLE -> a_vld=b_vld=0, a_skew=b_skew=0 throughout.
REQ-042 Back-to-back tiles: start in cycle after done -> second tile timing identical to REQ-037, shifted.

Source files
------------

// File: rtl/operand_skewer_pkg.sv
// Shared types and helpers for the operand skewer that feeds a systolic array.
package operand_skewer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_safe(input int x);
    int w;
    w = $clog2(x);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/operand_skewer_delay.sv
// Per-lane data+valid shift register; lane depth sets the operand skew.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_d,
  input  logic          i_v,
  output logic [DW-1:0] o_d,
  output logic          o_v
);

  logic [DEPTH-1:0][DW-1:0] r_d;
  logic [DEPTH-1:0]         r_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d <= '0;
      r_v <= '0;
    end else begin
      r_d[0] <= i_d;
      r_v[0] <= i_v;
      for (int k = 1; k < DEPTH; k++) begin
        r_d[k] <= r_d[k-1];
        r_v[k] <= r_v[k-1];
      end
    end
  end

  assign o_d = r_d[DEPTH-1];
  assign o_v = r_v[DEPTH-1];

endmodule

// File: rtl/operand_skewer.sv
// Tile sequencer plus per-lane skew delay lines in front of an N1 x N2 systolic array.
module operand_skewer
  import operand_skewer_pkg::*;
#(
  parameter int N1 = 4,
  parameter int N2 = 4,
  parameter int M  = 8,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [N1*DW-1:0] a_data,
  input  logic [N2*DW-1:0] b_data,
  output logic [N1*DW-1:0] a_skew,
  output logic [N1-1:0]    a_vld,
  output logic [N2*DW-1:0] b_skew,
  output logic [N2-1:0]    b_vld,
  output logic            clear,
  output logic            busy,
  output logic            done
);

  localparam int BW = clog2_safe(M + 1);
  localparam int FL = N1 + N2 - 1;
  localparam int FW = clog2_safe(FL + 1);

  state_t        r_state, w_next;
  logic [BW-1:0] r_beat;
  logic [FW-1:0] r_flush;
  logic          r_clear;
  logic          w_acc, w_last, w_fl_end;

  assign w_acc    = (r_state == S_FEED) && in_valid;
  assign w_last   = w_acc && (r_beat == BW'(M - 1));
  assign w_fl_end = (r_flush == FW'(FL - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)    w_next = S_FEED;
      S_FEED:  if (w_last)   w_next = S_FLUSH;
      S_FLUSH: if (w_fl_end) w_next = S_DONE;
      S_DONE:                w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat  <= '0;
      r_flush <= '0;
      r_clear <= 1'b0;
    end else begin
      r_clear <= (r_state == S_IDLE) && start;
      if (w_acc) r_beat <= w_last ? '0 : r_beat + 1'b1;
      if (r_state == S_FLUSH) r_flush <= w_fl_end ? '0 : r_flush + 1'b1;
      else                    r_flush <= '0;
    end
  end

  assign clear = r_clear;
  assign busy  = (r_state == S_FEED) || (r_state == S_FLUSH);
  assign done  = (r_state == S_DONE);

  // Non-accepted cycles inject zero bubbles so lanes keep draining in every state.
  logic [N1-1:0][DW-1:0] w_a_in;
  logic [N2-1:0][DW-1:0] w_b_in;

  generate
    for (genvar i = 0; i < N1; i++) begin : g_a
      assign w_a_in[i] = w_acc ? a_data[i*DW +: DW] : '0;
      skew_delay_line #(.DEPTH(i + 1), .DW(DW)) u_dl (
        .clk (clk),
        .rst (rst),
        .i_d (w_a_in[i]),
        .i_v (w_acc),
        .o_d (a_skew[i*DW +: DW]),
        .o_v (a_vld[i])
      );
    end
    for (genvar j = 0; j < N2; j++) begin : g_b
      assign w_b_in[j] = w_acc ? b_data[j*DW +: DW] : '0;
      skew_delay_line #(.DEPTH(j + 1), .DW(DW)) u_dl (
        .clk (clk),
        .rst (rst),
        .i_d (w_b_in[j]),
        .i_v (w_acc),
        .o_d (b_skew[j*DW +: DW]),
        .o_v (b_vld[j])
      );
    end
  endgenerate

endmodule

// File: tb/tb_operand_skewer.sv
// Randomized bench for operand_skewer with a tile-timeline reference model.
module tb_operand_skewer;
  localparam int N1 = 4, N2 = 4, M = 8, DW = 8;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [N1*DW-1:0] a_data, a_skew;
  logic [N2*DW-1:0] b_data, b_skew;
  logic [N1-1:0] a_vld;
  logic [N2-1:0] b_vld;
  logic clear, busy, done;

  operand_skewer #(.N1(N1), .N2(N2), .M(M), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a_data(a_data), .b_data(b_data), .a_skew(a_skew), .a_vld(a_vld),
    .b_skew(b_skew), .b_vld(b_vld), .clear(clear), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0, n_clear = 0, n_done = 0;
  int last_clear = -1, last_done = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Reference: input history of accepted beats plus a tile timeline
  logic              hv [MAXC];
  logic [N1*DW-1:0]  ha [MAXC];
  logic [N2*DW-1:0]  hb [MAXC];
  logic [DW-1:0]     a3_hist [MAXC];
  int  tile_active = 0, t_start = 0, n_acc = 0, t_last = 0;

  always @(negedge clk) begin : cmp
    int t, idx;
    logic acc;
    logic [N1*DW-1:0] ea;
    logic [N2*DW-1:0] eb;
    logic [N1-1:0] eav;
    logic [N2-1:0] ebv;
    logic eclr, ebusy, edone;
    t = cyc;
    ea = '0; eb = '0; eav = '0; ebv = '0;
    eclr = 0; ebusy = 0; edone = 0;
    if (rst) begin
      for (int i = 0; i < N1; i++) begin
        idx = t - i - 1;
        if (idx >= 0) begin ea[i*DW +: DW] = ha[idx][i*DW +: DW]; eav[i] = hv[idx]; end
      end
      for (int j = 0; j < N2; j++) begin
        idx = t - j - 1;
        if (idx >= 0) begin eb[j*DW +: DW] = hb[idx][j*DW +: DW]; ebv[j] = hv[idx]; end
      end
      eclr  = tile_active != 0 && t == t_start + 1;
      edone = tile_active != 0 && n_acc == M && t == t_last + N1 + N2;
      ebusy = tile_active != 0 && t > t_start && !(n_acc == M && t >= t_last + N1 + N2);
    end
    chk("a_skew", 64'(a_skew), 64'(ea));
    chk("a_vld",  64'(a_vld),  64'(eav));
    chk("b_skew", 64'(b_skew), 64'(eb));
    chk("b_vld",  64'(b_vld),  64'(ebv));
    chk("clear_busy_done", 64'({clear, busy, done}), 64'({eclr, ebusy, edone}));
    if (clear === 1'b1) begin n_clear++; last_clear = t; end
    if (done === 1'b1)  begin n_done++;  last_done = t;  end
    a3_hist[t] = a_skew[3*DW +: DW];
    acc = 0;
    if (!rst) tile_active = 0;
    else begin
      acc = tile_active != 0 && t > t_start && n_acc < M && in_valid;
      if (acc) begin n_acc++; if (n_acc == M) t_last = t; end
      if (edone) tile_active = 0;
      else if (tile_active == 0 && start) begin tile_active = 1; t_start = t; n_acc = 0; end
    end
    hv[t] = acc;
    ha[t] = acc ? a_data : '0;
    hb[t] = acc ? b_data : '0;
  end

  function automatic logic [N1*DW-1:0] ra();
    logic [N1*DW-1:0] r;
    for (int k = 0; k < N1; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction
  function automatic logic [N2*DW-1:0] rb();
    logic [N2*DW-1:0] r;
    for (int k = 0; k < N2; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction
  function automatic logic [N1*DW-1:0] pat(input int b);
    logic [N1*DW-1:0] r;
    for (int k = 0; k < N1; k++) r[k*DW +: DW] = DW'(16 * b + k);
    return r;
  endfunction

  task automatic drive(input logic st, input logic iv,
                       input logic [N1*DW-1:0] a, input logic [N2*DW-1:0] b);
    start = st; in_valid = iv; a_data = a; b_data = b;
    @(posedge clk); #1;
  endtask

  // One tile from start pulse through the done cycle; returns the start cycle.
  task automatic tile(input int gap1, input int gap2, input bit use_pat, input int pv,
                      input bit poke, output int t0);
    int nb, c;
    logic iv;
    t0 = cyc;
    drive(1'b1, 1'b1, ra(), rb());
    nb = 0; c = 0;
    while (nb < M) begin
      c++;
      iv = (c == gap1 || c == gap2) ? 1'b0 : ($urandom_range(99) < pv);
      if (iv) nb++;
      drive(poke && c == 2, iv, use_pat ? pat(nb) : ra(), rb());
    end
    for (int k = 0; k < N1 + N2; k++)
      drive(poke && (k == 3 || k == N1 + N2 - 1), 1'($urandom), ra(), rb());
  endtask

  initial begin
    int t0, nc, nd;
    rst = 0; start = 0; in_valid = 0; a_data = '0; b_data = '0;
    @(posedge clk); #1;
    repeat (3) drive(1'b1, 1'b1, ra(), rb());
    chk("reset_outputs", 64'({a_skew, a_vld, b_skew, b_vld, clear, busy, done}), 64'd0);
    rst = 1;
    repeat (5) drive(1'b0, 1'b1, ra(), rb());

    tile(0, 0, 1, 100, 0, t0);
    chk("clear_cycle", 64'(last_clear), 64'(t0 + 1));
    chk("lane3_beat1", 64'(a3_hist[t0 + 5]), 64'h13);
    chk("done_cycle", 64'(last_done), 64'(t0 + 16));

    tile(0, 0, 1, 100, 0, t0);
    chk("b2b_clear", 64'(last_clear), 64'(t0 + 1));
    chk("b2b_done", 64'(last_done), 64'(t0 + 16));

    tile(3, 4, 0, 100, 0, t0);
    chk("gap_done", 64'(last_done), 64'(t0 + 18));

    nc = n_clear; nd = n_done;
    tile(0, 0, 0, 100, 1, t0);
    chk("poke_clears", 64'(n_clear - nc), 64'd1);
    chk("poke_dones", 64'(n_done - nd), 64'd1);

    nd = n_done;
    drive(1'b1, 1'b0, ra(), rb());
    for (int b = 1; b <= M; b++) drive(1'b0, 1'b1, pat(b), rb());
    repeat (3) drive(1'b0, 1'b0, ra(), rb());
    rst = 0; #1;
    chk("rst_flush_outputs", 64'({a_skew, a_vld, b_skew, b_vld, clear, busy, done}), 64'd0);
    repeat (2) drive(1'b0, 1'b1, ra(), rb());
    rst = 1;
    repeat (12) drive(1'b0, 1'b1, ra(), rb());
    chk("rst_no_done", 64'(n_done - nd), 64'd0);
    tile(0, 0, 1, 100, 0, t0);
    chk("post_rst_done", 64'(last_done), 64'(t0 + 16));

    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(3)) drive(1'($urandom), 1'($urandom), ra(), rb());
      tile(0, 0, 0, $urandom_range(30, 100), 1'($urandom), t0);
    end
    repeat (4) drive(1'b0, 1'b1, ra(), rb());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
